// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter. An accept in cycle T gives
// tx_data_valid in T+1. req_ready stays low until the frame completes or times out.
module uart_tx_sched #(
  parameter int N_REQ        = 4,
  parameter int Width        = 8,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*Width-1:0] req_data,
  input  logic [N_REQ-1:0]       req_par_en,
  input  logic [N_REQ-1:0]       req_par_typ,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       grant,
  output logic [Width-1:0]       tx_p_data,
  output logic                   tx_data_valid,
  output logic                   tx_par_en,
  output logic                   tx_par_typ,
  input  logic                   tx_busy,
  output logic                   active,
  output logic                   timeout_err
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_EXP = CNT_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t           state_q;
  logic [PTR_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N_REQ-1:0] grant_q;
  logic [Width-1:0] p_data_q;
  logic             data_valid_q;
  logic             par_en_q;
  logic             par_typ_q;
  logic             active_q;
  logic             timeout_err_q;

  logic [Width-1:0] req_byte [N_REQ];
  logic [PTR_W-1:0] win_idx_d;
  logic             win_found_d;
  logic             accept_d;
  logic [N_REQ-1:0] grant_d;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign req_byte[g] = req_data[g*Width +: Width];
  end

  // First valid requester strictly after ptr_q, wrapping.
  always_comb begin
    win_idx_d   = ptr_q;
    win_found_d = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      logic [PTR_W-1:0] cand;
      cand = PTR_W'((int'(ptr_q) + k) % N_REQ);
      if (!win_found_d && req_valid[cand]) begin
        win_found_d = 1'b1;
        win_idx_d   = cand;
      end
    end
  end

  always_comb begin
    accept_d = rst && (state_q == IDLE) && !tx_busy && win_found_d;
    grant_d  = '0;
    if (accept_d) begin
      grant_d[win_idx_d] = 1'b1;
    end
  end

  assign req_ready = grant_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      ptr_q         <= PTR_RST;
      cnt_q         <= '0;
      grant_q       <= '0;
      p_data_q      <= '0;
      data_valid_q  <= 1'b0;
      par_en_q      <= 1'b0;
      par_typ_q     <= 1'b0;
      active_q      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      data_valid_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            p_data_q     <= req_byte[win_idx_d];
            par_en_q     <= req_par_en[win_idx_d];
            par_typ_q    <= req_par_typ[win_idx_d];
            grant_q      <= grant_d;
            ptr_q        <= win_idx_d;
            data_valid_q <= 1'b1;
            active_q     <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state_q <= WAIT_DONE;
          end else if (cnt_q >= CNT_EXP) begin
            // Transmitter never took the byte; drop it and free the line.
            timeout_err_q <= 1'b1;
            grant_q       <= '0;
            active_q      <= 1'b0;
            state_q       <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            grant_q  <= '0;
            active_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          grant_q  <= '0;
          active_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign grant         = grant_q;
  assign tx_p_data     = p_data_q;
  assign tx_data_valid = data_valid_q;
  assign tx_par_en     = par_en_q;
  assign tx_par_typ    = par_typ_q;
  assign active        = active_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a behavioural one-clock-per-bit transmitter.
module tb_uart_tx_sched;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_par_en;
  logic [N-1:0]   req_par_typ;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic [W-1:0]   tx_p_data;
  logic           tx_data_valid;
  logic           tx_par_en;
  logic           tx_par_typ;
  logic           tx_busy;
  logic           active;
  logic           timeout_err;

  logic        mdl_en, man_busy, mdl_busy, tx_line;
  logic [10:0] mdl_sh;
  int          mdl_left;
  logic [15:0] line_cap;
  int          line_idx;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  uart_tx_sched #(.N_REQ(N), .Width(W), .BUSY_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data),
    .req_par_en(req_par_en), .req_par_typ(req_par_typ),
    .req_ready(req_ready), .grant(grant),
    .tx_p_data(tx_p_data), .tx_data_valid(tx_data_valid),
    .tx_par_en(tx_par_en), .tx_par_typ(tx_par_typ),
    .tx_busy(tx_busy), .active(active), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter stand-in: Busy rises the cycle after Data_valid, one bit per clock.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mdl_busy <= 1'b0;
      mdl_left <= 0;
      mdl_sh   <= '1;
    end else if (mdl_busy) begin
      mdl_sh   <= {1'b1, mdl_sh[10:1]};
      mdl_left <= mdl_left - 1;
      if (mdl_left == 1) mdl_busy <= 1'b0;
    end else if (mdl_en && tx_data_valid) begin
      mdl_busy <= 1'b1;
      mdl_left <= tx_par_en ? 11 : 10;
      mdl_sh   <= tx_par_en ? {1'b1, (tx_par_typ ? ~^tx_p_data : ^tx_p_data), tx_p_data, 1'b0}
                            : {2'b11, tx_p_data, 1'b0};
    end
  end

  assign tx_line = mdl_busy ? mdl_sh[0] : 1'b1;
  assign tx_busy = mdl_en ? mdl_busy : man_busy;

  always @(negedge clk) begin
    if (mdl_busy && line_idx < 16) begin
      line_cap[line_idx] = tx_line;
      line_idx = line_idx + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_dv(input string tag, input int budget, output int t);
    for (int i = 0; i < budget && !tx_data_valid; i++) tick();
    t = cyc;
    check(tag, 32'(tx_data_valid), 32'd1);
  endtask

  // Returns the first cycle in which tx_busy reads low after having been high.
  task automatic wait_fall(input string tag, input int budget, output int t);
    for (int i = 0; i < budget && !tx_busy; i++) tick();
    for (int i = 0; i < budget && tx_busy; i++) tick();
    t = cyc;
    check(tag, 32'(tx_busy), 32'd0);
  endtask

  logic [3:0] exp_grant [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [7:0] exp_byte  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end of the test sequence");
    $fatal(1);
  end

  initial begin
    int t_dv, t_fall;
    rst = 1'b0; req_valid = 4'hF; req_data = 32'h44332211;
    req_par_en = '0; req_par_typ = '0;
    mdl_en = 1'b1; man_busy = 1'b0; line_cap = '0; line_idx = 0;
    t_fall = 0;

    // Reset held with every requester pending
    repeat (3) tick();
    check("rst_ready",   32'(req_ready), 32'h0);
    check("rst_grant",   32'(grant), 32'h0);
    check("rst_dv",      32'(tx_data_valid), 32'h0);
    check("rst_pdata",   32'(tx_p_data), 32'h0);
    check("rst_par_en",  32'(tx_par_en), 32'h0);
    check("rst_par_typ", 32'(tx_par_typ), 32'h0);
    check("rst_active",  32'(active), 32'h0);
    check("rst_timeout", 32'(timeout_err), 32'h0);

    // Release: requester 0 first, then strict rotation with 2-cycle turnaround
    rst = 1'b1;
    #1;
    check("rel_ready0", 32'(req_ready), 32'h1);
    for (int f = 0; f < 8; f++) begin
      wait_dv("fair_dv", 40, t_dv);
      check("fair_grant", 32'(grant), 32'(exp_grant[f]));
      check("fair_data",  32'(tx_p_data), 32'(exp_byte[f % 4]));
      if (f > 0) check("fair_gap", 32'(t_dv - t_fall), 32'd2);
      if (f == 7) req_valid = '0;
      wait_fall("fair_fall", 40, t_fall);
    end
    tick();
    check("fair_grant_clr", 32'(grant), 32'h0);
    tick();

    // Single request with odd parity on requester 2
    req_data = 32'h44A52211; req_par_en = 4'b0100; req_par_typ = 4'b0100;
    line_cap = '0; line_idx = 0;
    req_valid = 4'b0100;
    #1;
    check("one_ready", 32'(req_ready), 32'h4);
    tick();
    check("one_dv",      32'(tx_data_valid), 32'h1);
    check("one_pdata",   32'(tx_p_data), 32'hA5);
    check("one_par_en",  32'(tx_par_en), 32'h1);
    check("one_par_typ", 32'(tx_par_typ), 32'h1);
    check("one_grant",   32'(grant), 32'h4);
    req_valid = '0; req_data = 32'h44002211; req_par_en = '0; req_par_typ = '0;
    tick();
    check("one_dv_pulse", 32'(tx_data_valid), 32'h0);
    check("one_hold",     32'(tx_p_data), 32'hA5);
    check("one_hold_par", 32'({tx_par_en, tx_par_typ}), 32'h3);
    wait_fall("one_fall", 40, t_fall);
    check("one_grant_end", 32'(grant), 32'h4);
    check("one_line",      32'(line_cap), 32'(11'b11_1010_0101_0));
    check("one_line_len",  32'(line_idx), 32'd11);
    tick();
    check("one_grant_clr", 32'(grant), 32'h0);

    // Timeout: transmitter never raises Busy
    mdl_en = 1'b0; man_busy = 1'b0;
    req_valid = 4'b0001;
    #1;
    check("to_ready", 32'(req_ready), 32'h1);
    tick();
    check("to_dv", 32'(tx_data_valid), 32'h1);
    req_valid = '0;
    tick();
    check("to_active", 32'(active), 32'h1);
    repeat (3) tick();
    check("to_early", 32'(timeout_err), 32'h0);
    tick();
    check("to_pulse",    32'(timeout_err), 32'h1);
    check("to_grant",    32'(grant), 32'h0);
    check("to_idle",     32'(active), 32'h0);
    tick();
    check("to_one_cyc",  32'(timeout_err), 32'h0);
    req_valid = 4'b0010;
    #1;
    check("to_next_ready", 32'(req_ready), 32'h2);
    tick();
    check("to_next_grant", 32'(grant), 32'h2);
    req_valid = '0; man_busy = 1'b1;
    repeat (4) tick();
    check("wd_active",  32'(active), 32'h1);
    check("wd_grant",   32'(grant), 32'h2);
    check("wd_no_to",   32'(timeout_err), 32'h0);

    // Reset mid-frame clears outputs without waiting for an edge
    rst = 1'b0;
    #1;
    check("mid_grant",  32'(grant), 32'h0);
    check("mid_active", 32'(active), 32'h0);
    check("mid_dv",     32'(tx_data_valid), 32'h0);
    tick();
    man_busy = 1'b0; req_valid = 4'hF;
    rst = 1'b1;
    #1;
    check("mid_restart", 32'(req_ready), 32'h1);
    req_valid = '0;
    tick();

    // Busy held by someone else blocks arbitration
    man_busy = 1'b1; req_valid = 4'b0001;
    #1;
    check("blk_ready0", 32'(req_ready), 32'h0);
    tick();
    check("blk_ready1",  32'(req_ready), 32'h0);
    check("blk_active",  32'(active), 32'h0);
    man_busy = 1'b0;
    #1;
    check("blk_release", 32'(req_ready), 32'h1);
    tick();
    check("blk_dv",    32'(tx_data_valid), 32'h1);
    check("blk_grant", 32'(grant), 32'h1);
    req_valid = '0;
    repeat (6) tick();
    check("blk_end_idle", 32'(active), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin transmit scheduler that shares one UART transmitter among `N_REQ` byte requesters. It arbitrates pending requests and captures the winner's byte and parity settings. It then drives the transmitter's `P_data`/`Data_valid`/`PAR_EN`/`PAR_TYP` inputs and tracks `Busy` until that frame completes. It sits between the host-side requesters and `UART_Tx`, on the same clock.

## Interface

**Parameters**
- `N_REQ`, default 4: number of requesters, legal 2..8.
- `Width`, default 8: data byte width; must equal the transmitter's `Width`.
- `BUSY_TIMEOUT`, default 4: cycles after `tx_data_valid` within which `tx_busy` must rise, legal ≥1.

**Ports**
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  requester i has a byte pending.
- `req_data`  in  N_REQ*Width  requester i byte at `[i*Width +: Width]`.
- `req_par_en`  in  N_REQ  per-requester parity enable.
- `req_par_typ`  in  N_REQ  per-requester parity type.
- `req_ready`  out  N_REQ  one-hot accept; a transfer occurs when `req_valid[i] && req_ready[i]`.
- `grant`  out  N_REQ  one-hot owner of the in-flight frame.
- `tx_p_data`  out  Width  to transmitter `P_data`.
- `tx_data_valid`  out  1  to transmitter `Data_valid`.
- `tx_par_en`  out  1  to transmitter `PAR_EN`.
- `tx_par_typ`  out  1  to transmitter `PAR_TYP`.
- `tx_busy`  in  1  from transmitter `Busy`.
- `active`  out  1  high whenever state ≠ IDLE.
- `timeout_err`  out  1  one-cycle pulse when the busy timeout expires.

## Operation

**States:** IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.

- **IDLE**
  - Arbitrate only when `tx_busy`=0.
  - The winner is the first i with `req_valid[i]=1`, searching from `(ptr+1) mod N_REQ` upward with wrap.
  - `req_ready[winner]` is asserted combinationally in the same cycle; all other bits are 0.
  - On the transfer, register:
    - `tx_p_data` ← the winner's byte;
    - `tx_par_en`, `tx_par_typ` ← the winner's parity settings;
    - `grant` ← onehot(winner);
    - `ptr` ← winner.
  - Then go to ISSUE.
  - If no `req_valid`, or `tx_busy`=1, stay in IDLE with `req_ready`=0.
- **ISSUE**
  - `tx_data_valid`=1 for exactly this one cycle.
  - Clear the timeout counter, then go to WAIT_BUSY unconditionally.
- **WAIT_BUSY**
  - If `tx_busy`=1, go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches `BUSY_TIMEOUT`-1 without busy, pulse `timeout_err` for one cycle, clear `grant`, and go to IDLE.
  - The dropped byte is not retried.
- **WAIT_DONE**
  - When `tx_busy`=0, clear `grant` and go to IDLE.
- **Register stability:** `tx_p_data`, `tx_par_en` and `tx_par_typ` hold constant from capture until the next capture. Parity settings therefore stay stable for the whole frame.
- **Round-robin pointer:** `ptr` resets to `N_REQ`-1, so requester 0 has first priority after reset.
- **Counter width:** clog2(`BUSY_TIMEOUT`+1). It never wraps; it saturates at the expiry value.

## Timing

- **Reset values:** asserting `rst` (low) forces, immediately and asynchronously:
  - state=IDLE, `ptr`=`N_REQ`-1, counter=0;
  - `grant`=0, `tx_data_valid`=0, `tx_p_data`=0, `tx_par_en`=0, `tx_par_typ`=0;
  - `active`=0, `timeout_err`=0.
  - `req_ready` decodes to 0 while `rst` is low.
- **Output registration:** all outputs except `req_ready` are registered.
- **Accept-to-issue latency:** a transfer in cycle T gives `tx_data_valid`=1 in T+1 and state WAIT_BUSY in T+2.
- **Turnaround:** after `tx_busy` falls at cycle F, state is IDLE at F+1. The next accept can occur at F+1, and the next `tx_data_valid` at F+2.
- **Reset mid-frame:** the scheduler returns to IDLE. It does not abort a transmitter frame; the transmitter shares `rst`.
- **Requester drops valid:**
  - If `req_valid` drops before the accept, no transfer occurs.
  - `req_data` changes after the accept have no effect.
- **Busy already high:** `tx_busy`=1 while in IDLE (e.g. a foreign frame in progress) blocks arbitration.
- **Busy seen early:** `tx_busy` rising in the ISSUE cycle is seen in WAIT_BUSY on the next cycle.
- **Boundary between WAIT_DONE and IDLE:** when WAIT_DONE exits and a new request is pending at the same time, the request is served on the following IDLE cycle. No state is skipped.

## Test plan

- **Reset:** hold `rst`=0 with all `req_valid`=1 → all outputs 0, `req_ready`=0. Release `rst`, with `tx_busy` modelled by a `UART_Tx` instance → requester 0 is accepted first with `grant`=0001.
- **Single request:** `req_valid`=0100, byte 0xA5, `req_par_en[2]`=1, `req_par_typ[2]`=1 → `req_ready`=0100 in T, then `tx_data_valid` pulse in T+1 with `tx_p_data`=0xA5, `tx_par_en`=1, `tx_par_typ`=1. `grant` stays 0100 until `tx_busy` falls. The serial line carries start, 0xA5 LSB-first, odd parity, stop.
- **Fairness:** all four `req_valid` held high for 8 frames → grant order 0,1,2,3,0,1,2,3. No gap between frames larger than 2 cycles of idle line.
- **Timeout:** stub `tx_busy`=0 forever, `BUSY_TIMEOUT`=4, one request → `timeout_err` pulses exactly 4 cycles after the WAIT_BUSY entry. State returns to IDLE, and the next request is accepted normally.
- **Reset mid-frame:** assert `rst` during WAIT_DONE → `grant`, `active` and `tx_data_valid` go to 0 immediately. After release, arbitration restarts at requester 0.
- **Blocked by busy:** force `tx_busy`=1 while in IDLE with `req_valid`=0001 → `req_ready` stays 0. When busy drops, accept occurs in that same cycle.
